// File: rtl/paridade_impar_pkg.sv
// Shared constants and helpers for the odd-parity checker.
// Latency: none (definitions only).
// Backpressure: not applicable.
package paridade_impar_pkg;

  localparam int WIDTH_DEF = 8;   // default in_data width
  localparam int CNT_W_DEF = 16;  // default odd_count width

  // XOR reduction of a vector: 1 when the number of ones is odd.
  function automatic logic odd_parity(input logic [WIDTH_DEF-1:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/paridade_impar_sync_parity_tree.sv
// Balanced XOR reduction tree, N inputs to one parity bit.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: in_bits[N-1:0] -> parity (1 when an odd number of inputs are set).
module parity_tree #(
  parameter int N = 3
) (
  input  logic [N-1:0] in_bits,
  output logic         parity
);

  // Pad the leaves up to a power of two with zeros (XOR identity), then
  // halve the vector per level so every path has the same XOR depth.
  localparam int LEVELS = (N > 1) ? $clog2(N) : 0;
  localparam int P      = 1 << LEVELS;

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [(P >> l)-1:0] v;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < P; i++) begin : g_bit
        if (i < N) begin : g_in
          assign v[i] = in_bits[i];
        end else begin : g_pad
          assign v[i] = 1'b0;
        end
      end
    end else begin : g_node
      for (genvar i = 0; i < (P >> l); i++) begin : g_bit
        assign v[i] = g_lvl[l-1].v[2*i] ^ g_lvl[l-1].v[2*i+1];
      end
    end
  end

  assign parity = g_lvl[LEVELS].v[0];

endmodule

// File: rtl/paridade_impar_sync.sv
// Odd-parity checker: 3-input combinational parity plus a registered word path
// Latency: s is combinational; s_q, out_*, odd_count, odd_seen one cycle.
// Backpressure: none, a valid word may arrive every cycle.
// Ports: clk, rst (sync, active-high); a/b/c -> s, s_q;
//        in_valid/in_data -> out_valid/out_data/out_parity;
//        clear resets odd_count (saturating) and odd_seen (sticky).
module paridade_impar_sync
  import paridade_impar_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             s,
  output logic             s_q,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic [CNT_W-1:0] odd_count,
  output logic             odd_seen
);

  logic word_par;
  logic cnt_full;

  parity_tree #(.N(3)) u_abc_tree (
    .in_bits ({a, b, c}),
    .parity  (s)
  );

  parity_tree #(.N(WIDTH)) u_word_tree (
    .in_bits (in_data),
    .parity  (word_par)
  );

  assign cnt_full = &odd_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q        <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_parity <= 1'b0;
      odd_count  <= '0;
      odd_seen   <= 1'b0;
    end else begin
      s_q       <= s;
      out_valid <= in_valid;
      // Data and parity hold across idle cycles.
      if (in_valid) begin
        out_data   <= in_data;
        out_parity <= word_par;
      end
      // clear beats a same-cycle increment; the word path above ignores it.
      if (clear) begin
        odd_count <= '0;
        odd_seen  <= 1'b0;
      end else if (in_valid && word_par) begin
        if (!cnt_full) begin
          odd_count <= odd_count + CNT_W'(1);
        end
        odd_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_paridade_impar_sync.sv
module tb_paridade_impar_sync;

  logic       clk = 1'b0;
  logic       run = 1'b0;
  logic       rst, a, b, c, in_valid, clear;
  logic [7:0] in_data;

  logic       s, s_q, out_valid, out_parity, odd_seen;
  logic [7:0] out_data;
  logic [15:0] odd_count;

  logic       s2, s_q2, out_valid2, out_parity2, odd_seen2;
  logic [7:0] out_data2;
  logic [1:0] odd_count2;

  int checks = 0;
  int errors = 0;

  always #5 if (run) clk = ~clk;

  paridade_impar_sync #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .s(s), .s_q(s_q),
    .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .out_valid(out_valid), .out_data(out_data), .out_parity(out_parity),
    .odd_count(odd_count), .odd_seen(odd_seen)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  paridade_impar_sync #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .s(s2), .s_q(s_q2),
    .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .out_valid(out_valid2), .out_data(out_data2), .out_parity(out_parity2),
    .odd_count(odd_count2), .odd_seen(odd_seen2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_s;
  logic [7:0] words [4];
  logic       pars  [4];
  logic [7:0] odd_words [5];

  initial begin
    rst = 1'b1; a = 0; b = 0; c = 0; in_valid = 0; in_data = 8'h00; clear = 0;

    // Exhaustive abc sweep, no clock running. exp_s[i] is s for abc = i.
    exp_s = 8'b1001_0110;
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #1;
      chk($sformatf("s_abc%0d", i), 32'(s), 32'(exp_s[i]));
      #9;
    end
    {a, b, c} = 3'b000;

    // Reset for two cycles, then check every registered output.
    run = 1'b1;
    repeat (2) tick();
    chk("rst_s_q", 32'(s_q), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_parity", 32'(out_parity), 0);
    chk("rst_odd_count", 32'(odd_count), 0);
    chk("rst_odd_seen", 32'(odd_seen), 0);
    rst = 1'b0;

    // Word stream.
    words[0] = 8'h01; pars[0] = 1'b1;
    words[1] = 8'h03; pars[1] = 1'b0;
    words[2] = 8'hFF; pars[2] = 1'b0;
    words[3] = 8'h80; pars[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      tick();
      chk($sformatf("word%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("word%0d_data", i), 32'(out_data), 32'(words[i]));
      chk($sformatf("word%0d_parity", i), 32'(out_parity), 32'(pars[i]));
    end
    chk("stream_odd_count", 32'(odd_count), 2);
    chk("stream_odd_seen", 32'(odd_seen), 1);

    // Idle cycle: odd data on the bus but not valid.
    in_valid = 1'b0;
    in_data  = 8'h07;
    tick();
    chk("gap_valid", 32'(out_valid), 0);
    chk("gap_data", 32'(out_data), 32'h80);
    chk("gap_parity", 32'(out_parity), 1);
    chk("gap_odd_count", 32'(odd_count), 2);

    // Clear, then saturation on the 2-bit counter.
    clear = 1'b1;
    tick();
    chk("clear_odd_count", 32'(odd_count), 0);
    chk("clear_odd_seen", 32'(odd_seen), 0);
    chk("clear_sat_count", 32'(odd_count2), 0);
    clear = 1'b0;
    odd_words[0] = 8'h01; odd_words[1] = 8'h02; odd_words[2] = 8'h04;
    odd_words[3] = 8'h08; odd_words[4] = 8'h10;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = odd_words[i];
      tick();
      chk($sformatf("sat_count%0d", i), 32'(odd_count2), (i < 3) ? i + 1 : 3);
      chk($sformatf("wide_count%0d", i), 32'(odd_count), i + 1);
    end

    // Clear beats a same-cycle odd word; word path still captures it.
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h07;
    tick();
    chk("prio_clear_count", 32'(odd_count), 0);
    chk("prio_clear_seen", 32'(odd_seen), 0);
    chk("prio_clear_data", 32'(out_data), 32'h07);
    chk("prio_clear_valid", 32'(out_valid), 1);
    clear   = 1'b0;
    in_data = 8'h01;
    tick();
    chk("pre_rst_count", 32'(odd_count), 1);

    // Reset beats clear and a valid word.
    rst = 1'b1; clear = 1'b1; in_valid = 1'b1; in_data = 8'h01;
    {a, b, c} = 3'b111;
    tick();
    chk("prio_rst_s_q", 32'(s_q), 0);
    chk("prio_rst_valid", 32'(out_valid), 0);
    chk("prio_rst_data", 32'(out_data), 0);
    chk("prio_rst_parity", 32'(out_parity), 0);
    chk("prio_rst_count", 32'(odd_count), 0);
    chk("prio_rst_seen", 32'(odd_seen), 0);

    // First word after reset release appears one cycle later.
    rst = 1'b0; clear = 1'b0; in_data = 8'h0B; {a, b, c} = 3'b000;
    tick();
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_data", 32'(out_data), 32'h0B);
    chk("post_rst_parity", 32'(out_parity), 1);
    chk("post_rst_count", 32'(odd_count), 1);
    in_valid = 1'b0;

    // s tracks at once, s_q follows one clock later.
    {a, b, c} = 3'b111;
    #1;
    chk("sq_s_111", 32'(s), 1);
    tick();
    chk("sq_111", 32'(s_q), 1);
    {a, b, c} = 3'b110;
    #1;
    chk("sq_s_110", 32'(s), 0);
    chk("sq_hold", 32'(s_q), 1);
    tick();
    chk("sq_110", 32'(s_q), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
